// File: rtl/line_buf_pkg.sv
// rtl/line_buf_pkg.sv - shared defaults and fill-state encoding for the 3-row line buffer
package line_buf_pkg;

    localparam int unsigned LB_WIDTH     = 24;
    localparam int unsigned LB_PIC_WIDTH = 640;

    typedef enum logic [1:0] {
        FILL0 = 2'd0,
        FILL1 = 2'd1,
        RUN   = 2'd2
    } lb_state_t;

endpackage

// File: rtl/line_buf_3row_line_ram.sv
// rtl/line_buf_3row_line_ram.sv - one line store, single-port, read-first, no reset
module line_ram #(
    parameter int WIDTH = 24,
    parameter int DEPTH = 640,
    parameter int AW    = (DEPTH > 1) ? $clog2(DEPTH) : 1
) (
    input  logic             clk,
    input  logic             we,
    input  logic [AW-1:0]    addr,
    input  logic [WIDTH-1:0] wdata,
    output logic [WIDTH-1:0] rdata
);

    logic [WIDTH-1:0] mem [DEPTH];

    // Old word is visible on rdata during the write cycle; the caller registers it.
    always_ff @(posedge clk) begin
        if (we) begin
            mem[addr] <= wdata;
        end
    end

    assign rdata = mem[addr];

endmodule

// File: rtl/line_buf_3row.sv
// rtl/line_buf_3row.sv - 3-row tap generator; LINE_BUF_BORDER_REPLICATE_EN enables edge rows
module line_buf_3row
    import line_buf_pkg::*;
#(
    parameter int WIDTH     = LB_WIDTH,
    parameter int PIC_WIDTH = LB_PIC_WIDTH
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             sof,
    input  logic             valid_in,
    input  logic [WIDTH-1:0] din,
    output logic             valid_out,
    output logic [WIDTH-1:0] row_top,
    output logic [WIDTH-1:0] row_mid,
    output logic [WIDTH-1:0] row_bot
);

    localparam int CW = (PIC_WIDTH > 1) ? $clog2(PIC_WIDTH) : 1;
    localparam logic [CW-1:0] COL_LAST = CW'(PIC_WIDTH - 1);

    lb_state_t        state_q, state_d, cur_st;
    logic [CW-1:0]    col_q, col_d, addr;
    logic             take_sof, wrap, ram_we;
    logic             valid_q, valid_d;
    logic [WIDTH-1:0] top_q, top_d, mid_q, mid_d, bot_q, bot_d;
    logic [WIDTH-1:0] l1_rd, l2_rd;

    // A qualified sof restarts the frame with this pixel as column 0 of line 0.
    assign take_sof = valid_in & sof;
    assign addr     = take_sof ? '0 : col_q;
    assign cur_st   = take_sof ? FILL0 : state_q;
    assign wrap     = (addr == COL_LAST);
    assign ram_we   = valid_in & rst_n;

    line_ram #(.WIDTH(WIDTH), .DEPTH(PIC_WIDTH), .AW(CW)) u_l1 (
        .clk   (clk),
        .we    (ram_we),
        .addr  (addr),
        .wdata (din),
        .rdata (l1_rd)
    );

    line_ram #(.WIDTH(WIDTH), .DEPTH(PIC_WIDTH), .AW(CW)) u_l2 (
        .clk   (clk),
        .we    (ram_we),
        .addr  (addr),
        .wdata (l1_rd),
        .rdata (l2_rd)
    );

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= FILL0;
            col_q   <= '0;
            valid_q <= 1'b0;
            top_q   <= '0;
            mid_q   <= '0;
            bot_q   <= '0;
        end else begin
            state_q <= state_d;
            col_q   <= col_d;
            valid_q <= valid_d;
            top_q   <= top_d;
            mid_q   <= mid_d;
            bot_q   <= bot_d;
        end
    end

    always_comb begin
        state_d = state_q;
        col_d   = col_q;
        if (valid_in) begin
            col_d = wrap ? '0 : addr + 1'b1;
            case (cur_st)
                FILL0:   state_d = wrap ? FILL1 : FILL0;
                FILL1:   state_d = wrap ? RUN : FILL1;
                default: state_d = RUN;
            endcase
        end
    end

    always_comb begin
        valid_d = 1'b0;
        top_d   = top_q;
        mid_d   = mid_q;
        bot_d   = bot_q;
        if (valid_in) begin
            bot_d = din;
            mid_d = l1_rd;
            top_d = l2_rd;
`ifdef LINE_BUF_BORDER_REPLICATE_EN
            valid_d = 1'b1;
            case (cur_st)
                FILL0: begin
                    top_d = din;
                    mid_d = din;
                end
                FILL1:   top_d = l1_rd;
                default: ;
            endcase
`else
            valid_d = (cur_st == RUN);
`endif
        end
    end

    assign valid_out = valid_q;
    assign row_top   = top_q;
    assign row_mid   = mid_q;
    assign row_bot   = bot_q;

endmodule

// File: tb/tb_line_buf_3row.sv
// tb/tb_line_buf_3row.sv - scoreboard bench for line_buf_3row, honours LINE_BUF_BORDER_REPLICATE_EN
module tb_line_buf_3row;

    localparam int W  = 24;
    localparam int PW = 4;

    logic         clk = 1'b0;
    logic         rst_n, sof, valid_in;
    logic [W-1:0] din;
    logic         valid_out;
    logic [W-1:0] row_top, row_mid, row_bot;

    int total = 0;
    int bad   = 0;
    logic [3*W-1:0] exp_q [$];

    line_buf_3row #(.WIDTH(W), .PIC_WIDTH(PW)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .sof       (sof),
        .valid_in  (valid_in),
        .din       (din),
        .valid_out (valid_out),
        .row_top   (row_top),
        .row_mid   (row_mid),
        .row_bot   (row_bot)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [3*W-1:0] act, input logic [3*W-1:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s act=%h exp=%h", name, act, exp);
        end
    endtask

    always @(negedge clk) begin
        if (valid_out === 1'b1) begin
            if (exp_q.size() == 0) begin
                total++;
                bad++;
                $display("FAIL unexpected_valid act=%h exp=none", {row_top, row_mid, row_bot});
            end else begin
                chk("taps", {row_top, row_mid, row_bot}, exp_q.pop_front());
            end
        end
    end

    // Pixel value = base + 16*line + col; expectation is pushed as the pixel is issued.
    task automatic pix(input int base, input int line, input int col, input bit s);
        int v;
        v        = base + 16 * line + col;
        sof      = s;
        valid_in = 1'b1;
        din      = W'(v);
`ifdef LINE_BUF_BORDER_REPLICATE_EN
        if (line == 0)      exp_q.push_back({W'(v), W'(v), W'(v)});
        else if (line == 1) exp_q.push_back({W'(v - 16), W'(v - 16), W'(v)});
        else                exp_q.push_back({W'(v - 32), W'(v - 16), W'(v)});
`else
        if (line >= 2) exp_q.push_back({W'(v - 32), W'(v - 16), W'(v)});
`endif
        @(posedge clk);
        #1;
        valid_in = 1'b0;
        sof      = 1'b0;
    endtask

    task automatic lines(input int base, input int first, input int last, input bit sof_first);
        for (int l = first; l <= last; l++)
            for (int c = 0; c < PW; c++)
                pix(base, l, c, sof_first && l == first && c == 0);
    endtask

    initial begin
        rst_n    = 1'b0;
        sof      = 1'b0;
        valid_in = 1'b0;
        din      = '0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        chk("reset_valid", {71'd0, valid_out}, 72'd0);
        chk("reset_taps", {row_top, row_mid, row_bot}, 72'd0);
        rst_n = 1'b1;

        // Frame A: lines 0-1, then line 2 up to col 1, then a 3-cycle stall.
        lines(0, 0, 1, 1'b1);
        pix(0, 2, 0, 1'b0);
        pix(0, 2, 1, 1'b0);
        @(negedge clk);
        repeat (3) begin
            @(posedge clk);
            @(negedge clk);
            chk("stall_valid", {71'd0, valid_out}, 72'd0);
            chk("stall_taps", {row_top, row_mid, row_bot}, {24'h01, 24'h11, 24'h21});
        end
        pix(0, 2, 2, 1'b0);
        pix(0, 2, 3, 1'b0);
        pix(0, 3, 0, 1'b0);
        pix(0, 3, 1, 1'b0);

        // Frame B: sof where line 3 col 2 would have been.
        pix(32'h100, 0, 0, 1'b1);
        for (int c = 1; c < PW; c++) pix(32'h100, 0, c, 1'b0);
        lines(32'h100, 1, 2, 1'b0);

        // Frame C: reset arrives with line 2 col 2 on the input.
        lines(32'h200, 0, 1, 1'b1);
        pix(32'h200, 2, 0, 1'b0);
        pix(32'h200, 2, 1, 1'b0);
        rst_n    = 1'b0;
        valid_in = 1'b1;
        din      = W'(32'h222);
        @(posedge clk);
        @(negedge clk);
        chk("midreset_valid", {71'd0, valid_out}, 72'd0);
        chk("midreset_taps", {row_top, row_mid, row_bot}, 72'd0);
        rst_n    = 1'b1;
        valid_in = 1'b0;

        // Frame D starts without sof.
        lines(32'h300, 0, 2, 1'b0);

        // Reset wins over sof+valid_in on the same edge.
        rst_n    = 1'b0;
        valid_in = 1'b1;
        sof      = 1'b1;
        din      = W'(32'h3ff);
        @(posedge clk);
        @(negedge clk);
        chk("rst_sof_valid", {71'd0, valid_out}, 72'd0);
        chk("rst_sof_taps", {row_top, row_mid, row_bot}, 72'd0);
        rst_n    = 1'b1;
        valid_in = 1'b0;
        sof      = 1'b0;

        // Frame E without sof: must start at col 0 of line 0.
        lines(32'h400, 0, 2, 1'b0);

        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("queue_empty", 72'(exp_q.size()), 72'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/line_buf_3row.md
LINE_BUF_3ROW -- requirements
Module: line_buf_3row

Interface
REQ-001 SHALL have parameter WIDTH, default 24: pixel width in bits, packed {R[23:16], G[15:8], B[7:0]}.
REQ-002 SHALL have parameter PIC_WIDTH, default 640: pixels per line; column counter width is $clog2(PIC_WIDTH).
REQ-003 SHALL have port clk, input, 1: the only clock; all logic on its rising edge.
REQ-004 SHALL have port rst_n, input, 1: reset, synchronous and active-low.
REQ-005 SHALL have port sof, input, 1: start of frame; qualified by valid_in; marks the first pixel of line 0.
REQ-006 SHALL have port valid_in, input, 1: din is valid this cycle.
REQ-007 SHALL have port din, input, WIDTH: raster-order pixel stream.
REQ-008 SHALL have port valid_out, output, 1: row taps are valid this cycle.
REQ-009 SHALL have ports row_top, row_mid and row_bot, output, WIDTH each: the same column of lines n-2, n-1 and n, feeding the 3x3 window's din1, din2 and din3.

Function
REQ-010 SHALL hold two line stores of PIC_WIDTH x WIDTH: L1 holds line n-1 and L2 holds line n-2.
REQ-011 SHALL, on valid_in at column c, register row_bot<=din, row_mid<=L1[c] and row_top<=L2[c], then write L1[c]<=din and L2[c]<=L1[c] (read-before-write at the same address).
REQ-012 SHALL have a latency of exactly 1 cycle: valid_out and the taps appear on the cycle after valid_in.
REQ-013 SHALL drive valid_out low, and hold all taps and the column counter, on any cycle without valid_in; a stall mid-line loses no data.
REQ-014 SHALL increment the column counter on each valid_in and wrap it from PIC_WIDTH-1 to 0.
REQ-015 SHALL implement a three-state FSM: FILL0 (line 0), FILL1 (line 1), RUN (line 2 onward).
REQ-016 SHALL advance the FSM FILL0->FILL1->RUN on the valid_in that wraps the column counter; RUN stays in RUN.
REQ-017 SHALL, when valid_in && sof, force the column counter to 1 and the state to FILL0 regardless of the current state, with that pixel processed as column 0 of line 0; a mid-line sof abandons the partial frame.
REQ-018 SHALL ignore sof when valid_in is low.
REQ-019 SHALL, without REQ-027, assert valid_out only for pixels accepted in RUN; the taps still update in FILL0 and FILL1 per REQ-011, but their values there are don't-care.

Reset
REQ-020 SHALL, with rst_n low at a clk edge, set valid_out=0, row_top=row_mid=row_bot=0, column counter=0 and state=FILL0.
REQ-021 SHALL give reset priority over valid_in and sof on the same edge.
REQ-022 SHALL NOT reset line-store contents; after reset they are unused until refilled.
REQ-023 SHALL, on reset mid-frame, treat the next valid_in pixel as column 0 of line 0, with or without sof.

Configuration
REQ-024 SHALL support macro LINE_BUF_BORDER_REPLICATE_EN.
REQ-025 SHALL, when the macro is undefined, emit H-2 valid lines per frame of H lines (first output line is line 2).
REQ-026 SHALL, when the macro is defined, assert valid_out for every valid_in in all states, giving H output lines.
REQ-027 SHALL, when the macro is defined, use border replication: in FILL0, top=mid=bot=din; in FILL1, top=mid=L1[c] and bot=din; RUN is per REQ-011.

Structure
REQ-028 SHALL take its FSM state enum (FILL0/FILL1/RUN) and the default WIDTH/PIC_WIDTH constants from shared package line_buf_pkg.
REQ-029 SHALL instantiate each line store as sub-module line_ram: single-port, read-first, synchronous, depth PIC_WIDTH; no reset.

Verification (PIC_WIDTH=4, pixel value = 16*line + column)
REQ-030 SHALL cover: rst_n low for 2 cycles, then sof+3 lines continuous -> no valid_out during lines 0-1; line 2 col 1 gives top=0x01, mid=0x11, bot=0x21 one cycle after the input.
REQ-031 SHALL cover: valid_in dropped for 3 cycles after line 2 col 1 -> valid_out low and taps held; col 2 then gives top=0x02, mid=0x12, bot=0x22.
REQ-032 SHALL cover: sof reasserted at line 3 col 2 -> state FILL0, no valid_out for the next 8 accepted pixels, correct taps from new line 2.
REQ-033 SHALL cover: rst_n low at line 2 col 2 -> all outputs 0 next cycle; the following pixel is treated as column 0 of line 0 (REQ-023), with no valid_out for 8 accepted pixels.
REQ-034 SHALL cover, with LINE_BUF_BORDER_REPLICATE_EN defined: line 0 col 3 -> top=mid=bot=0x03; line 1 col 3 -> top=mid=0x03, bot=0x13; 12 valid_out per 3-line frame.
REQ-035 SHALL cover: valid_in && sof on the same edge as rst_n low -> reset wins, state FILL0, col 0, valid_out=0.
